// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: lends a shared N-bit ALU to an iterative shift-add multiplier,
// passing the datapath straight through to the ALU whenever no multiply is running.
module alu_mul_sequencer #(
    parameter int N          = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] dp_a,
    input  logic [N-1:0] dp_b,
    input  logic [3:0]   dp_op,
    output logic [N-1:0] dp_result,
    output logic         dp_grant,
    input  logic         start,
    input  logic [N-1:0] mul_a,
    input  logic [N-1:0] mul_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t        state;
    logic [N-1:0]  m, q, p;
    logic [CW-1:0] cnt;
    logic          last;
    assign last      = (cnt == CW'(N - 1)) || (EARLY_EXIT && ((q >> 1) == '0));
    assign dp_grant  = ~busy;
    assign alu_a     = busy ? p : dp_a;
    assign alu_b     = busy ? (q[0] ? m : '0) : dp_b;
    assign alu_op    = busy ? 4'b0010 : dp_op;
    assign dp_result = alu_result;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            q       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= mul_a;
                        q     <= mul_b;
                        p     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    p   <= alu_result;
                    m   <= m << 1;
                    q   <= q >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        product <= alu_result;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
